ecc_52_err_mon: RTL

Registered consumer stage placed directly after the 52-bit lockstep ECC decoder on the FIFO read path. It registers the corrected read word and forwards it downstream. It also keeps saturating error statistics and captures the most severe error seen. For correctable errors it issues a scrub write-back request to the FIFO write port through a req/ack handshake.

---
 rtl/ecc_52_pkg.sv | 26 ++
 rtl/ecc_sat_cnt.sv | 35 +++
 rtl/ecc_52_err_mon.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ecc_52_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_52_pkg
// Purpose  : Shared definitions for the 52-bit ECC error monitor: error-type
//            codes (ordered by severity), scrub FSM state encodings and the
//            default decoded data width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ecc_52_pkg;

  localparam int DEF_DATA_WIDTH = 52;

  // Codes are ordered so that a plain numeric compare ranks severity.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SBIT  = 2'd1;
  localparam logic [1:0] ERR_DBIT  = 2'd2;
  localparam logic [1:0] ERR_FAULT = 2'd3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } scrub_state_t;

endpackage
`default_nettype wire

// File: rtl/ecc_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sat_cnt
// Purpose  : Saturating event counter with synchronous clear. A clear that
//            coincides with an increment leaves the counter at 1.
// Ports    : clk, rst_n    - clock, asynchronous active-low reset
//            inc           - count one event this cycle
//            clr           - clear counter (applied before inc)
//            cnt           - current count, sticks at all-ones
// Revision : 1.0 - initial release
// ============================================================================
module ecc_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? C_ONE : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ecc_52_err_mon.sv
`default_nettype none
// ============================================================================
// Module   : ecc_52_err_mon
// Purpose  : Registered consumer stage after the 52-bit lockstep ECC decoder.
//            Forwards the corrected word, keeps saturating error counters,
//            captures the most severe error, raises a level interrupt and
//            requests scrub write-backs for corrected (single-bit) errors.
// Ports    : clk, rst_n                      - clock, async active-low reset
//            rd_vld/rd_addr/data_in          - decoder word and its address
//            sbit_err/dbit_err/ecc_fault     - decoder status flags
//            out_vld/out_data/out_err        - registered word downstream
//            cnt_sbit/cnt_dbit/cnt_fault     - saturating event counters
//            cap_vld/cap_type/cap_addr       - most severe captured error
//            irq                             - level interrupt
//            clr                             - clear statistics and flags
//            scrub_req/addr/data, scrub_ack  - scrub write-back handshake
//            scrub_ovf                       - sticky dropped-scrub flag
// Revision : 1.0 - initial release
// ============================================================================
module ecc_52_err_mon
  import ecc_52_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  cnt_sbit,
  output logic [CNT_WIDTH-1:0]  cnt_dbit,
  output logic [CNT_WIDTH-1:0]  cnt_fault,
  output logic                  cap_vld,
  output logic [1:0]            cap_type,
  output logic [ADDR_WIDTH-1:0] cap_addr,
  output logic                  irq,
  input  logic                  clr,
  output logic                  scrub_req,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic [DATA_WIDTH-1:0] scrub_data,
  input  logic                  scrub_ack,
  output logic                  scrub_ovf
);

  scrub_state_t          r_state;
  logic                  w_is_sbit, w_is_dbit, w_is_fault;
  logic [1:0]            w_evt_type;
  logic                  w_cap_vld_base, w_cap_vld_nxt;
  logic [1:0]            w_cap_type_base, w_cap_type_nxt;
  logic [ADDR_WIDTH-1:0] w_cap_addr_nxt;
  logic                  w_drop, w_ovf_nxt, w_irq_nxt;

  // Fault dominates dbit, dbit dominates sbit: exactly one class per cycle.
  assign w_is_fault = rd_vld & ecc_fault;
  assign w_is_dbit  = rd_vld & dbit_err & ~ecc_fault;
  assign w_is_sbit  = rd_vld & sbit_err & ~dbit_err & ~ecc_fault;

  always_comb begin
    w_evt_type = ERR_NONE;
    if (w_is_fault)     w_evt_type = ERR_FAULT;
    else if (w_is_dbit) w_evt_type = ERR_DBIT;
    else if (w_is_sbit) w_evt_type = ERR_SBIT;
  end

  // Capture: clear is applied first, then the new event competes against
  // whatever survives the clear.
  always_comb begin
    w_cap_vld_base  = cap_vld & ~clr;
    w_cap_type_base = clr ? ERR_NONE : cap_type;
    w_cap_vld_nxt   = w_cap_vld_base;
    w_cap_type_nxt  = w_cap_type_base;
    w_cap_addr_nxt  = clr ? '0 : cap_addr;
    if ((w_evt_type != ERR_NONE) &&
        (!w_cap_vld_base || (w_evt_type > w_cap_type_base))) begin
      w_cap_vld_nxt  = 1'b1;
      w_cap_type_nxt = w_evt_type;
      w_cap_addr_nxt = rd_addr;
    end
  end

  // A corrected error arriving while a scrub is outstanding (including the
  // ack cycle) is dropped; the flag survives a coincident clr.
  assign w_drop    = w_is_sbit & (r_state == S_REQ);
  assign w_ovf_nxt = (scrub_ovf & ~clr) | w_drop;
  assign w_irq_nxt = (w_cap_vld_nxt & (w_cap_type_nxt >= ERR_DBIT)) | w_ovf_nxt;

  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_sbit (
    .clk(clk), .rst_n(rst_n), .inc(w_is_sbit), .clr(clr), .cnt(cnt_sbit)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_dbit (
    .clk(clk), .rst_n(rst_n), .inc(w_is_dbit), .clr(clr), .cnt(cnt_dbit)
  );
  ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_fault (
    .clk(clk), .rst_n(rst_n), .inc(w_is_fault), .clr(clr), .cnt(cnt_fault)
  );

  // Data path, capture and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      cap_vld   <= 1'b0;
      cap_type  <= ERR_NONE;
      cap_addr  <= '0;
      scrub_ovf <= 1'b0;
      irq       <= 1'b0;
    end else begin
      out_vld   <= rd_vld;
      out_err   <= rd_vld & (dbit_err | ecc_fault);
      if (rd_vld) out_data <= data_in;
      cap_vld   <= w_cap_vld_nxt;
      cap_type  <= w_cap_type_nxt;
      cap_addr  <= w_cap_addr_nxt;
      scrub_ovf <= w_ovf_nxt;
      irq       <= w_irq_nxt;
    end
  end

  // Scrub request FSM; clr deliberately has no effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      scrub_req  <= 1'b0;
      scrub_addr <= '0;
      scrub_data <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_is_sbit) begin
        r_state    <= S_REQ;
        scrub_req  <= 1'b1;
        scrub_addr <= rd_addr;
        scrub_data <= data_in;
      end
    end else begin
      if (scrub_ack) begin
        r_state   <= S_IDLE;
        scrub_req <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
